uart_fifo_core: RTL and testbench

Synchronous first-word-fall-through FIFO used as the UART receive buffer (and, at narrower width, the transmit buffer). It sits between the receiver state machine and the register interface. It tracks occupancy and flags overrun/underrun. It also reports whether any stored character carries a line error (break, parity or framing).

---
 rtl/uart_fifo_core.sv | 131 +++++++++++++
 tb/tb_uart_fifo_core.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// First-word-fall-through FIFO for the UART receive/transmit path.
// Tracks occupancy, sticky overrun/underrun, and a line-error summary over stored characters.
module uart_fifo_core #(
  parameter int unsigned fifo_width     = 11,
  parameter int unsigned fifo_depth     = 16,
  parameter int unsigned fifo_counter_w = 5
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic [fifo_width-1:0]     data_in,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      fifo_reset,
  input  logic                      reset_status,
  output logic [fifo_width-1:0]     data_out,
  output logic [fifo_counter_w-1:0] count,
  output logic                      overrun,
  output logic                      underrun,
  output logic                      error_bit
);

  localparam int unsigned PtrW = $clog2(fifo_depth);

  logic [fifo_width-1:0]     mem_q [fifo_depth];
  logic [PtrW-1:0]           top_q, top_d;
  logic [PtrW-1:0]           bottom_q, bottom_d;
  logic [fifo_counter_w-1:0] count_q, count_d;
  logic                      overrun_q, overrun_d;
  logic                      underrun_q, underrun_d;
  logic                      full_c, empty_c, we_c;
  logic                      ovr_evt_c, udr_evt_c;

  assign full_c  = (count_q == fifo_counter_w'(fifo_depth));
  assign empty_c = (count_q == '0);
  // A push lands in storage unless the FIFO is full and nothing leaves this cycle.
  assign we_c    = push && !fifo_reset && (!full_c || pop);

  always_comb begin
    top_d      = top_q;
    bottom_d   = bottom_q;
    count_d    = count_q;
    ovr_evt_c  = 1'b0;
    udr_evt_c  = 1'b0;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (fifo_reset) begin
      top_d      = '0;
      bottom_d   = '0;
      count_d    = '0;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (full_c) begin
            ovr_evt_c = 1'b1;
          end else begin
            top_d   = top_q + PtrW'(1);
            count_d = count_q + fifo_counter_w'(1);
          end
        end
        2'b01: begin
          if (empty_c) begin
            udr_evt_c = 1'b1;
          end else begin
            bottom_d = bottom_q + PtrW'(1);
            count_d  = count_q - fifo_counter_w'(1);
          end
        end
        2'b11: begin
          top_d = top_q + PtrW'(1);
          if (empty_c) begin
            count_d = count_q + fifo_counter_w'(1);
          end else begin
            bottom_d = bottom_q + PtrW'(1);
          end
        end
        default: begin
        end
      endcase
      // A new event in the same cycle as reset_status keeps the flag set.
      overrun_d  = (overrun_q  && !reset_status) || ovr_evt_c;
      underrun_d = (underrun_q && !reset_status) || udr_evt_c;
    end
  end

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      top_q      <= '0;
      bottom_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      top_q      <= top_d;
      bottom_q   <= bottom_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      for (int i = 0; i < int'(fifo_depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_c) begin
      mem_q[top_q] <= data_in;
    end
  end

  // Line-error summary: only entries within count of bottom are considered valid.
  always_comb begin
    logic [PtrW-1:0] offset;
    error_bit = 1'b0;
    offset    = '0;
    for (int i = 0; i < int'(fifo_depth); i++) begin
      offset = PtrW'(i) - bottom_q;
      if ((fifo_counter_w'(offset) < count_q) && (|mem_q[i][2:0])) begin
        error_bit = 1'b1;
      end
    end
  end

  assign data_out = mem_q[bottom_q];
  assign count    = count_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Randomized and directed bench for uart_fifo_core against a queue-based reference model.
module tb_uart_fifo_core;

  localparam int unsigned W = 11;
  localparam int unsigned D = 16;
  localparam int unsigned CW = 5;

  logic          clk;
  logic          wb_rst_i;
  logic [W-1:0]  data_in;
  logic          push, pop, fifo_reset, reset_status;
  logic [W-1:0]  data_out;
  logic [CW-1:0] count;
  logic          overrun, underrun, error_bit;

  int n_tests;
  int n_fail;

  logic [W-1:0] mq[$];
  logic         m_ovr, m_udr;

  uart_fifo_core #(.fifo_width(W), .fifo_depth(D), .fifo_counter_w(CW)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .data_in(data_in), .push(push), .pop(pop),
    .fifo_reset(fifo_reset), .reset_status(reset_status), .data_out(data_out),
    .count(count), .overrun(overrun), .underrun(underrun), .error_bit(error_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_err();
    foreach (mq[i]) if (mq[i][2:0] != 3'b000) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic pu, input logic po, input logic [W-1:0] d,
                            input logic fr, input logic rs);
    logic oe, ue;
    oe = 1'b0;
    ue = 1'b0;
    if (fr) begin
      mq.delete();
      m_ovr = 1'b0;
      m_udr = 1'b0;
    end else begin
      if (pu && po) begin
        if (mq.size() != 0) void'(mq.pop_front());
        mq.push_back(d);
      end else if (pu) begin
        if (mq.size() < D) mq.push_back(d);
        else oe = 1'b1;
      end else if (po) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else ue = 1'b1;
      end
      if (rs) begin
        m_ovr = 1'b0;
        m_udr = 1'b0;
      end
      m_ovr = m_ovr | oe;
      m_udr = m_udr | ue;
    end
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(mq.size()));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("underrun", 32'(underrun), 32'(m_udr));
    check("error_bit", 32'(error_bit), 32'(model_err()));
    if (mq.size() > 0) check("data_out", 32'(data_out), 32'(mq[0]));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic cyc(input logic pu, input logic po, input logic [W-1:0] d,
                     input logic fr = 1'b0, input logic rs = 1'b0);
    push = pu; pop = po; data_in = d; fifo_reset = fr; reset_status = rs;
    @(posedge clk);
    model_step(pu, po, d, fr, rs);
    #1;
    push = 1'b0; pop = 1'b0; fifo_reset = 1'b0; reset_status = 1'b0;
    check_all();
  endtask

  task automatic do_async_reset();
    push = 1'b0; pop = 1'b0; fifo_reset = 1'b0; reset_status = 1'b0;
    #2 wb_rst_i = 1'b0;
    #1;
    mq.delete();
    m_ovr = 1'b0;
    m_udr = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_error_bit", 32'(error_bit), 32'd0);
    @(negedge clk);
    wb_rst_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    m_ovr = 1'b0;
    m_udr = 1'b0;
    wb_rst_i = 1'b1;
    push = 1'b0; pop = 1'b0; data_in = '0; fifo_reset = 1'b0; reset_status = 1'b0;
    @(posedge clk);
    #1;
    do_async_reset();

    // Basic ordering
    cyc(1, 0, 11'h555); cyc(1, 0, 11'h2A8); cyc(1, 0, 11'h7F8);
    check("tp1_count3", 32'(count), 32'd3);
    check("tp1_head", 32'(data_out), 32'h555);
    cyc(0, 1, '0); cyc(0, 1, '0);
    check("tp1_head_after_pops", 32'(data_out), 32'h7F8);
    check("tp1_count1", 32'(count), 32'd1);
    check("tp1_err", 32'(error_bit), 32'd0);

    // Overrun on the 17th push
    cyc(0, 0, '0, 1'b1);
    for (int i = 0; i < 17; i++) cyc(1, 0, W'((i + 1) * 8));
    check("tp2_count_full", 32'(count), 32'd16);
    check("tp2_overrun", 32'(overrun), 32'd1);
    check("tp2_head", 32'(data_out), 32'h008);
    cyc(0, 0, '0, 1'b0, 1'b1);
    check("tp2_overrun_clr", 32'(overrun), 32'd0);

    // Underrun and push+pop on empty
    cyc(0, 0, '0, 1'b1);
    cyc(0, 1, '0);
    check("tp3_underrun", 32'(underrun), 32'd1);
    cyc(0, 0, '0, 1'b0, 1'b1);
    cyc(1, 1, 11'h3C0);
    check("tp3_pp_count", 32'(count), 32'd1);
    check("tp3_pp_no_udr", 32'(underrun), 32'd0);

    // Error summary follows valid entries only
    cyc(0, 0, '0, 1'b1);
    cyc(1, 0, 11'h001); cyc(1, 0, 11'h100);
    check("tp4_err_set", 32'(error_bit), 32'd1);
    cyc(0, 1, '0);
    check("tp4_err_popped", 32'(error_bit), 32'd0);
    cyc(1, 0, 11'h004);
    check("tp4_err_break", 32'(error_bit), 32'd1);

    // Sustained push+pop while full across pointer wrap
    cyc(0, 0, '0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1, 0, W'(i << 3));
    for (int i = 16; i < 36; i++) cyc(1, 1, W'(i << 3));
    check("tp5_count", 32'(count), 32'd16);
    check("tp5_no_ovr", 32'(overrun), 32'd0);
    check("tp5_head", 32'(data_out), 32'(W'(20 << 3)));

    // fifo_reset beats a simultaneous push
    cyc(0, 0, '0, 1'b1);
    cyc(1, 0, 11'h001);
    for (int i = 0; i < 4; i++) cyc(1, 0, W'(i << 4));
    cyc(0, 1, '0); cyc(0, 1, '0); cyc(0, 1, '0); cyc(0, 1, '0); cyc(0, 1, '0); cyc(0, 1, '0);
    for (int i = 0; i < 5; i++) cyc(1, 0, W'(i == 2 ? 11'h002 : 11'h0F0));
    check("tp6_count5", 32'(count), 32'd5);
    check("tp6_err", 32'(error_bit), 32'd1);
    cyc(1, 0, 11'h7FF, 1'b1);
    check("tp6_fr_count", 32'(count), 32'd0);
    check("tp6_fr_err", 32'(error_bit), 32'd0);
    check("tp6_fr_ovr", 32'(overrun), 32'd0);

    // Randomized traffic with drifting fill bias
    for (int i = 0; i < 3000; i++) begin
      int bias;
      logic pu, po, fr, rs;
      bias = ((i / 150) % 2 == 0) ? 70 : 30;
      pu = ($urandom_range(99) < bias);
      po = ($urandom_range(99) < 100 - bias);
      fr = ($urandom_range(99) == 0);
      rs = ($urandom_range(19) == 0);
      cyc(pu, po, W'($urandom_range(2047)), fr, rs);
    end

    // Async reset in the middle of traffic
    for (int i = 0; i < 6; i++) cyc(1, 0, W'($urandom_range(2047)));
    do_async_reset();
    cyc(1, 0, 11'h123);
    check("post_rst_head", 32'(data_out), 32'h123);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
